// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures an external PWM waveform. It reports the period (rising edge to
// rising edge) and the high time, both counted in clk cycles. It is the
// counterpart of the PWM generator and is used for loopback self-test as well
// as for measuring PWM signals that arrive from outside the chip.
//
// The asynchronous pwm_in is first passed through a synchroniser and then
// edge-detected. A small FSM times the synchronised waveform. Each finished
// measurement is published to the register interface through a valid/ack
// handshake. Sticky flags report three conditions: an overwritten result, a
// line stuck high, and a line stuck low.
//
// Parameters
//   CNT_W        width of counters, timeout and result registers
//   SYNC_STAGES  number of flops in the pwm_in synchroniser (>= 2)
//
// Ports
//   clk          peripheral clock
//   rst_n        synchronous, active-low reset
//   cap_en       capture enable; 0 = idle and clear status
//   pwm_in       asynchronous PWM input
//   timeout      stuck-level limit in cycles; 0 disables the check
//   cap_ack      consumer acknowledge; clears cap_valid
//   cap_period   last measured period in cycles
//   cap_high     last measured high time in cycles
//   cap_valid    result pending, held until cap_ack
//   cap_overrun  sticky: a result was overwritten while still unacknowledged
//   stuck_hi     sticky: input stayed high for timeout cycles
//   stuck_lo     sticky: input stayed low until the count reached timeout
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             pwm_in,
  input  logic [CNT_W-1:0] timeout,
  input  logic             cap_ack,
  output logic [CNT_W-1:0] cap_period,
  output logic [CNT_W-1:0] cap_high,
  output logic             cap_valid,
  output logic             cap_overrun,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RISE = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_LOW       = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next_sat;
  logic [CNT_W-1:0]       hi_cnt;
  logic                   timeout_hit;
  logic                   publish;

  // The synchroniser and edge-detect delay keep running while capture is
  // disabled. Re-enabling therefore never sees a stale level as a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Event decode shared by the FSM and the result registers.
  // When a timeout and a real edge land in the same cycle, the timeout wins:
  // the level has then lasted the full limit, so the measurement is dropped.
  always_comb begin
    cnt_next_sat = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    timeout_hit  = 1'b0;
    if ((timeout != '0) && (cnt == timeout) &&
        ((state == ST_HIGH) || (state == ST_LOW))) begin
      timeout_hit = 1'b1;
    end
    publish = (state == ST_LOW) && rise && !timeout_hit;
  end

  // Measurement FSM and counters.
  // cnt restarts at 1 in the cycle after a rise and counts every cycle through
  // the high and low phases. Its value in the next rise cycle is therefore the
  // full period. It saturates instead of wrapping, so an over-long period
  // reads back as all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_cnt <= '0;
    end else if (!cap_en) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          // The partial period that was in progress at enable (or after a
          // timeout) is discarded. Timing starts only at a genuine rise.
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (timeout_hit) begin
            state <= ST_WAIT_RISE;
          end else begin
            cnt <= cnt_next_sat;
            if (fall) begin
              hi_cnt <= cnt;
              state  <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (timeout_hit) begin
            state <= ST_WAIT_RISE;
          end else if (rise) begin
            cnt   <= CNT_ONE;
            state <= ST_HIGH;
          end else begin
            cnt <= cnt_next_sat;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Published results. They survive a cap_en drop so that software can still
  // read the last measurement after stopping capture. Only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_period <= '0;
      cap_high   <= '0;
    end else if (cap_en && publish) begin
      cap_period <= cnt;
      cap_high   <= hi_cnt;
    end
  end

  // Handshake and overrun tracking.
  // An ack that arrives together with a publish consumes the old result, so
  // the new one is pending and nothing was lost. No overrun is flagged then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid   <= 1'b0;
      cap_overrun <= 1'b0;
    end else if (!cap_en) begin
      cap_valid   <= 1'b0;
      cap_overrun <= 1'b0;
    end else if (publish) begin
      cap_valid <= 1'b1;
      if (cap_valid && !cap_ack) begin
        cap_overrun <= 1'b1;
      end
    end else if (cap_ack) begin
      cap_valid <= 1'b0;
    end
  end

  // Stuck-level flags. They are sticky until the line produces a complete,
  // successfully published period again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else if (!cap_en) begin
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else if (publish) begin
      stuck_hi <= 1'b0;
      stuck_lo <= 1'b0;
    end else if (timeout_hit) begin
      if (state == ST_HIGH) begin
        stuck_hi <= 1'b1;
      end else begin
        stuck_lo <= 1'b1;
      end
    end
  end

endmodule
